// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU. Ops 0-6 finish in one cycle; MUL runs a shift-add loop, one multiplier bit per cycle.
module seq_alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [3:0]            flags
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);

    if (W < 4 || (W & (W - 1)) != 0) begin : g_bad_width
        $error("seq_alu: DATA_WIDTH must be a power of two >= 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t state, state_nxt;

    logic          accept, is_mul, last, alu_c, alu_v;
    logic [SW-1:0] cnt, sh;
    logic [W-1:0]  mcand, alu_r;
    logic [W:0]    add_w, sub_w, step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        in_ready  = state == IDLE || (state == HOLD && out_ready);
        out_valid = state == HOLD;
        accept    = in_valid && in_ready;
        is_mul    = mode == 3'd7;
        last      = cnt == SW'(W - 1);
        state_nxt = state;
        if (accept)                     state_nxt = is_mul ? BUSY : HOLD;
        else if (state == BUSY && last) state_nxt = HOLD;
        else if (state == HOLD && out_ready) state_nxt = IDLE;
    end

    always_comb begin
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} - {1'b0, b};
        sh    = b[SW-1:0];
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (mode)
            3'd0: begin
                alu_r = add_w[W-1:0];
                alu_c = add_w[W];
                alu_v = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
            end
            3'd1: begin
                alu_r = sub_w[W-1:0];
                alu_c = sub_w[W];
                alu_v = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
            end
            3'd2:    alu_r = a & b;
            3'd3:    alu_r = a | b;
            3'd4:    alu_r = a ^ b;
            3'd5:    alu_r = a << sh;
            3'd6:    alu_r = a >> sh;
            default: alu_r = '0;
        endcase
        // result_hi accumulates the partial product while result shifts the multiplier out
        step = {1'b0, result_hi} + (result[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
            mcand     <= '0;
            cnt       <= '0;
        end else if (accept) begin
            mcand     <= a;
            cnt       <= '0;
            result_hi <= '0;
            result    <= is_mul ? b : alu_r;
            flags     <= is_mul ? 4'b0 : {alu_c, alu_v, alu_r[W-1], alu_r == '0};
        end else if (state == BUSY) begin
            cnt       <= cnt + SW'(1);
            result_hi <= step[W:1];
            result    <= {step[0], result[W-1:1]};
            if (last) flags <= {|step[W:1], 1'b0, step[0], {step, result[W-1:1]} == '0};
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
    logic       clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic       in_ready, out_valid;
    logic [7:0] a = 0, b = 0, result, result_hi;
    logic [2:0] mode = 0;
    logic [3:0] flags;
    int total = 0, bad = 0;

    seq_alu #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    // returns {hi, lo, carry, overflow, negative, zero}
    function automatic logic [19:0] model(input int x, input int y, input int m);
        int p, r, hi, sx, sy, s;
        logic c, v;
        hi = 0; c = 0; v = 0;
        sx = x >= 128 ? x - 256 : x;
        sy = y >= 128 ? y - 256 : y;
        case (m)
            0: begin p = x + y; r = p % 256; c = p > 255; s = sx + sy; v = s > 127 || s < -128; end
            1: begin r = (x - y + 256) % 256; c = x < y; s = sx - sy; v = s > 127 || s < -128; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = (x << (y % 8)) % 256;
            6: r = x >> (y % 8);
            default: begin p = x * y; r = p % 256; hi = p / 256; c = hi != 0; end
        endcase
        return {hi[7:0], r[7:0], c, v, r >= 128, r == 0 && hi == 0};
    endfunction

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] m,
                          output logic [19:0] got, output int lat);
        int w;
        a = x; b = y; mode = m; in_valid = 1; out_ready = 1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        in_valid = 0; a = 8'($urandom); b = 8'($urandom); mode = 3'($urandom);
        lat = 0;
        while (lat < 50) begin
            @(negedge clk); lat++;
            if (out_valid) break;
        end
        got = {result_hi, result, flags};
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({out_valid, result, result_hi, flags} !== 21'b0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {out_valid, result, result_hi, flags});
        end
        rst = 0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ready in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub;
        logic [19:0] got;
        int lat;
        run_op(8'hFF, 8'h01, 3'd0, got, lat);
        total++;
        if (got !== {8'h00, 8'h00, 4'b1001}) begin bad++; $display("FAIL add_ff_01 got=%h want=00009", got); end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
        run_op(8'h80, 8'h01, 3'd1, got, lat);
        total++;
        if (got !== {8'h00, 8'h7F, 4'b0100}) begin bad++; $display("FAIL sub_80_01 got=%h want=007f4", got); end
        run_op(8'h03, 8'h0A, 3'd1, got, lat);
        total++;
        if (got !== {8'h00, 8'hF9, 4'b1010}) begin bad++; $display("FAIL sub_03_0a got=%h want=00f9a", got); end
    endtask

    task automatic test_edges;
        logic [19:0] got;
        int lat;
        run_op(8'hA5, 8'h08, 3'd5, got, lat);
        total++;
        if (got !== {8'h00, 8'hA5, 4'b0010}) begin bad++; $display("FAIL shl_amount0 got=%h want=00a52", got); end
        run_op(8'hA5, 8'hF8, 3'd6, got, lat);
        total++;
        if (got !== {8'h00, 8'hA5, 4'b0010}) begin bad++; $display("FAIL shr_upper_ignored got=%h want=00a52", got); end
        run_op(8'hFF, 8'h07, 3'd5, got, lat);
        total++;
        if (got !== {8'h00, 8'h80, 4'b0010}) begin bad++; $display("FAIL shl_by7 got=%h want=00802", got); end
        run_op(8'h01, 8'h01, 3'd6, got, lat);
        total++;
        if (got !== {8'h00, 8'h00, 4'b0001}) begin bad++; $display("FAIL shr_to_zero got=%h want=00001", got); end
        run_op(8'h00, 8'h37, 3'd7, got, lat);
        total++;
        if (got !== {8'h00, 8'h00, 4'b0001}) begin bad++; $display("FAIL mul_zero got=%h want=00001", got); end
    endtask

    task automatic test_mul;
        int cyc, busy;
        a = 8'hFF; b = 8'hFF; mode = 3'd7; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        cyc = 0; busy = 0;
        while (cyc < 30) begin
            @(negedge clk); cyc++;
            a = ~a; b = 8'(cyc);
            if (out_valid) break;
            if (!in_ready) busy++;
        end
        total++;
        if (busy !== 8) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=8", busy); end
        total++;
        if (cyc !== 9) begin bad++; $display("FAIL mul_latency got=%0d want=9", cyc); end
        total++;
        if ({result_hi, result, flags} !== {8'hFE, 8'h01, 4'b1000}) begin
            bad++; $display("FAIL mul_ff_ff got=%h want=fe018", {result_hi, result, flags});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        a = 8'h81; b = 8'h09; mode = 3'd5; in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        mode = 3'd0;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, result_hi, result, flags} !== {2'b10, 8'h00, 8'h02, 4'b0000}) begin
                bad++; $display("FAIL hold_stable cyc=%0d got v=%b r=%b res=%h hi=%h f=%b want v=1 r=0 res=02 hi=00 f=0000",
                                i, out_valid, in_ready, result, result_hi, flags);
            end
        end
        @(posedge clk); #1;
        a = 8'hA5; b = 8'hFF; mode = 3'd4; in_valid = 1; out_ready = 1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        total++;
        if ({out_valid, result, flags} !== {1'b1, 8'h5A, 4'b0000}) begin
            bad++; $display("FAIL xor_after_hold got v=%b res=%h f=%b want v=1 res=5a f=0000", out_valid, result, flags);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] xa [12];
        logic [7:0] xb [12];
        logic [2:0] xm [12];
        logic [19:0] exp;
        xa[0] = 8'hC3; xb[0] = 8'h0F; xm[0] = 3'd2;
        xa[1] = 8'hC0; xb[1] = 8'h0F; xm[1] = 3'd3;
        xa[2] = 8'h80; xb[2] = 8'h07; xm[2] = 3'd6;
        for (int i = 3; i < 12; i++) begin
            xa[i] = 8'($urandom); xb[i] = 8'($urandom); xm[i] = 3'($urandom_range(0, 6));
        end
        out_ready = 1;
        for (int i = 0; i < 12; i++) begin
            a = xa[i]; b = xb[i]; mode = xm[i]; in_valid = 1;
            @(posedge clk); #1;
            @(negedge clk);
            exp = model(int'(xa[i]), int'(xb[i]), int'(xm[i]));
            total++;
            if ({out_valid, result_hi, result, flags} !== {1'b1, exp}) begin
                bad++; $display("FAIL b2b op=%0d mode=%0d got v=%b %h want v=1 %h",
                                i, xm[i], out_valid, {result_hi, result, flags}, exp);
            end
        end
        in_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul;
        logic [19:0] got;
        int lat, seen;
        a = 8'h37; b = 8'h5B; mode = 3'd7; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 1;
        #1;
        total++;
        if ({out_valid, result_hi, result, flags} !== 21'b0) begin
            bad++; $display("FAIL rst_mid_mul got=%h want=0", {out_valid, result_hi, result, flags});
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rst_discard out_valid_cycles=%0d want=0", seen); end
        @(posedge clk); #1;
        run_op(8'h02, 8'h03, 3'd0, got, lat);
        total++;
        if (got !== {8'h00, 8'h05, 4'b0000} || lat !== 1) begin
            bad++; $display("FAIL add_after_rst got=%h lat=%0d want=00050 lat=1", got, lat);
        end
    endtask

    task automatic test_random;
        logic [19:0] got, exp;
        logic [7:0] x, y;
        logic [2:0] m;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom); y = 8'($urandom); m = 3'($urandom);
            exp = model(int'(x), int'(y), int'(m));
            run_op(x, y, m, got, lat);
            total++;
            if (got !== exp || lat !== (m == 3'd7 ? 9 : 1)) begin
                bad++; $display("FAIL random i=%0d a=%h b=%h mode=%0d got=%h lat=%0d want=%h lat=%0d",
                                i, x, y, m, got, lat, exp, m == 3'd7 ? 9 : 1);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_edges;
        test_mul;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_mul;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
